slave_port_initiator: RTL and testbench
=======================================

Name: slave_port_initiator

Overview:
- Initiator that drives the simulation top's slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size in; Sout_Rdata_ram / Sout_DataRdy out).
- Lets a testbench or debug loader preload input arrays into main's internal memories and dump results back, instead of tying the slave port to zero.
- Accepts one read or write command at a time over a valid/ready interface and drives a single lane (LANE) of the packed multi-lane port.
- Returns one response per command, with a timeout error.

Parameters:
- N_CH, 2, number of lanes in the packed slave port.
- LANE, 0, lane index driven by this initiator (0..N_CH-1).
- ADDR_W, 7, address bits per lane.
- DATA_W, 8, data bits per lane.
- SIZE_W, 4, access-size bits per lane (value = access width in bits, 8 max for DATA_W=8).
- TIMEOUT, 255, maximum wait cycles for DataRdy before error; 8-bit counter.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  initiator can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_size  in  SIZE_W  access size in bits.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data (0 for writes and errors).
- rsp_err  out  1  1 = timeout.
- S_oe_ram  out  N_CH  read-enable per lane.
- S_we_ram  out  N_CH  write-enable per lane.
- S_addr_ram  out  N_CH*ADDR_W  packed addresses.
- S_Wdata_ram  out  N_CH*DATA_W  packed write data.
- S_data_ram_size  out  N_CH*SIZE_W  packed sizes.
- Sout_Rdata_ram  in  N_CH*DATA_W  packed read data.
- Sout_DataRdy  in  N_CH  per-lane completion.

Behaviour:
- Reset (reset=0, async):
  - state IDLE; all S_* outputs 0; rsp_valid=0, rsp_rdata=0, rsp_err=0; cmd_ready=0 during reset; timeout counter 0.
- Lane packing:
  - Lane i occupies bits [i*W +: W] of each packed bus.
  - Lanes other than LANE are driven 0 at all times.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, register addr/wdata/size/write and go to REQ.
  - Command fields are sampled only at the handshake.
- REQ (registered outputs):
  - Drive S_oe_ram[LANE]=!write, S_we_ram[LANE]=write, plus addr, size, and wdata (writes only; 0 for reads).
  - Hold the request every cycle until completion.
  - Counter increments each REQ cycle.
  - Sout_DataRdy[LANE]=1 sampled on the edge: capture Sout_Rdata lane (reads) into rsp_rdata, set rsp_err=0, deassert all S_* next cycle, go to RSP.
  - Counter reaches TIMEOUT without DataRdy: deassert request, rsp_rdata=0, rsp_err=1, go to RSP.
  - DataRdy in the same cycle the counter hits TIMEOUT: success wins.
- RSP:
  - rsp_valid=1, cmd_ready=0.
  - On rsp_ready, go to IDLE and clear rsp_valid, rsp_err and the counter.
  - rsp_rdata holds its value until the next capture.
- Latency: command accept to first S_oe/S_we high = 1 cycle. DataRdy edge to rsp_valid = 1 cycle. Minimum command-to-command spacing = 3 cycles + DataRdy wait.
- Sout_DataRdy outside REQ, or on other lanes, is ignored.
- Reset asserted mid-transaction aborts immediately: outputs zero, no response issued.
- No pipelining: only one outstanding command.

Test Plan:
- Reset: hold reset=0 with cmd_valid=1 → all S_* = 0, cmd_ready=0, rsp_valid=0; release → cmd_ready=1 next cycle.
- Write: cmd write addr=0x12 wdata=0xA5 size=8 on LANE=0; stub raises DataRdy[0] 2 cycles after we → S_we_ram=2'b01, S_addr_ram=14'h0012, S_Wdata_ram=16'h00A5, S_data_ram_size=8'h08 held 2 cycles; then rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read on LANE=1: addr=0x05; stub returns Sout_Rdata_ram=16'h3C00 with DataRdy=2'b10 → S_oe_ram=2'b10, S_addr_ram=14'h0280; rsp_rdata=0x3C, rsp_err=0.
- Timeout: TIMEOUT=4, never raise DataRdy → request held exactly 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0. Repeat with DataRdy on the 4th cycle → rsp_err=0.
- Backpressure and stray DataRdy: keep rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, cmd_ready=0. DataRdy pulsed while in IDLE → no response produced.
- Reset mid-REQ: assert reset during a read wait → S_oe_ram=0 asynchronously, no rsp_valid after release; next command completes normally.

Source files
------------

// File: rtl/slave_port_initiator_if.sv
// Bundle between the slave-port initiator and its environment.
// Carries the command/response handshake and the packed multi-lane slave memory port.
// master: the initiator's view (takes commands, drives the memory port).
// slave : the environment's view (issues commands, answers on the memory port).
interface slave_port_initiator_if #(
    parameter int unsigned N_CH   = 2,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SIZE_W = 4
);
    // command channel
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_write;
    logic [ADDR_W-1:0]        cmd_addr;
    logic [DATA_W-1:0]        cmd_wdata;
    logic [SIZE_W-1:0]        cmd_size;
    // response channel
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_W-1:0]        rsp_rdata;
    logic                     rsp_err;
    // packed slave memory port
    logic [N_CH-1:0]          S_oe_ram;
    logic [N_CH-1:0]          S_we_ram;
    logic [N_CH*ADDR_W-1:0]   S_addr_ram;
    logic [N_CH*DATA_W-1:0]   S_Wdata_ram;
    logic [N_CH*SIZE_W-1:0]   S_data_ram_size;
    logic [N_CH*DATA_W-1:0]   Sout_Rdata_ram;
    logic [N_CH-1:0]          Sout_DataRdy;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
        input  Sout_Rdata_ram, Sout_DataRdy,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
        output Sout_Rdata_ram, Sout_DataRdy,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
    );
endinterface

// File: rtl/slave_port_initiator.sv
// Single-command initiator for the slave memory port of the simulation top.
// Accepts one read/write over a valid/ready command channel, drives lane LANE of the
// packed port until Sout_DataRdy[LANE] or a timeout, then returns one response.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - command/response handshake plus packed slave port (master modport)
module slave_port_initiator #(
    parameter int unsigned N_CH    = 2,
    parameter int unsigned LANE    = 0,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SIZE_W  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    slave_port_initiator_if.master bus
);
    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;

    state_e              r_state,  w_state_d;
    logic                r_cmd_ready, w_cmd_ready_d;
    logic                r_oe,     w_oe_d;
    logic                r_we,     w_we_d;
    logic [ADDR_W-1:0]   r_addr,   w_addr_d;
    logic [DATA_W-1:0]   r_wdata,  w_wdata_d;
    logic [SIZE_W-1:0]   r_size,   w_size_d;
    logic [7:0]          r_cnt,    w_cnt_d;
    logic                r_rsp_valid, w_rsp_valid_d;
    logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_d;
    logic                r_rsp_err,   w_rsp_err_d;

    logic [7:0]          w_cnt_inc;
    logic                w_lane_rdy;
    logic [DATA_W-1:0]   w_lane_rdata;

    assign w_cnt_inc    = r_cnt + 8'd1;
    assign w_lane_rdy   = bus.Sout_DataRdy[LANE];
    assign w_lane_rdata = bus.Sout_Rdata_ram[LANE*DATA_W +: DATA_W];

    always_comb begin
        w_state_d     = r_state;
        w_oe_d        = r_oe;
        w_we_d        = r_we;
        w_addr_d      = r_addr;
        w_wdata_d     = r_wdata;
        w_size_d      = r_size;
        w_cnt_d       = r_cnt;
        w_rsp_valid_d = r_rsp_valid;
        w_rsp_rdata_d = r_rsp_rdata;
        w_rsp_err_d   = r_rsp_err;

        unique case (r_state)
            StIdle: begin
                // r_cmd_ready stays low for the first cycle out of reset
                if (bus.cmd_valid && r_cmd_ready) begin
                    w_state_d = StReq;
                    w_oe_d    = !bus.cmd_write;
                    w_we_d    = bus.cmd_write;
                    w_addr_d  = bus.cmd_addr;
                    w_wdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    w_size_d  = bus.cmd_size;
                    w_cnt_d   = '0;
                end
            end
            StReq: begin
                // Completion is checked first so a DataRdy on the last allowed cycle wins
                if (w_lane_rdy || (w_cnt_inc == TimeoutCnt)) begin
                    w_state_d     = StRsp;
                    w_rsp_valid_d = 1'b1;
                    w_rsp_err_d   = !w_lane_rdy;
                    w_rsp_rdata_d = (w_lane_rdy && r_oe) ? w_lane_rdata : '0;
                    w_oe_d        = 1'b0;
                    w_we_d        = 1'b0;
                    w_addr_d      = '0;
                    w_wdata_d     = '0;
                    w_size_d      = '0;
                end
                w_cnt_d = w_cnt_inc;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    w_state_d     = StIdle;
                    w_rsp_valid_d = 1'b0;
                    w_rsp_err_d   = 1'b0;
                    w_cnt_d       = '0;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_cmd_ready_d = (w_state_d == StIdle);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= StIdle;
            r_cmd_ready <= 1'b0;
            r_oe        <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_size      <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cmd_ready <= w_cmd_ready_d;
            r_oe        <= w_oe_d;
            r_we        <= w_we_d;
            r_addr      <= w_addr_d;
            r_wdata     <= w_wdata_d;
            r_size      <= w_size_d;
            r_cnt       <= w_cnt_d;
            r_rsp_valid <= w_rsp_valid_d;
            r_rsp_rdata <= w_rsp_rdata_d;
            r_rsp_err   <= w_rsp_err_d;
        end
    end

    // Only lane LANE is ever driven; the rest of each packed bus stays zero.
    always_comb begin
        bus.cmd_ready       = r_cmd_ready;
        bus.rsp_valid       = r_rsp_valid;
        bus.rsp_rdata       = r_rsp_rdata;
        bus.rsp_err         = r_rsp_err;
        bus.S_oe_ram        = '0;
        bus.S_we_ram        = '0;
        bus.S_addr_ram      = '0;
        bus.S_Wdata_ram     = '0;
        bus.S_data_ram_size = '0;
        bus.S_oe_ram[LANE]                            = r_oe;
        bus.S_we_ram[LANE]                            = r_we;
        bus.S_addr_ram[LANE*ADDR_W +: ADDR_W]         = r_addr;
        bus.S_Wdata_ram[LANE*DATA_W +: DATA_W]        = r_wdata;
        bus.S_data_ram_size[LANE*SIZE_W +: SIZE_W]    = r_size;
    end
endmodule

// File: tb/tb_slave_port_initiator.sv
// Bench for slave_port_initiator: two instances (lane 0 with a short timeout, lane 1
// with a longer one) share stimulus; sel picks which one is commanded and observed.
module tb_slave_port_initiator;
    localparam int unsigned Tmo0 = 4;
    localparam int unsigned Tmo1 = 8;

    logic clk;
    logic rst_n;
    logic sel;

    logic        cmd_valid;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [3:0]  cmd_size;
    logic        rsp_ready;
    logic [15:0] rdat;
    logic [1:0]  dr;

    slave_port_initiator_if #(.N_CH(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4)) if0 ();
    slave_port_initiator_if #(.N_CH(2), .ADDR_W(7), .DATA_W(8), .SIZE_W(4)) if1 ();

    slave_port_initiator #(.N_CH(2), .LANE(0), .ADDR_W(7), .DATA_W(8), .SIZE_W(4),
                           .TIMEOUT(Tmo0))
        u_dut0 (.clock(clk), .reset(rst_n), .bus(if0.master));
    slave_port_initiator #(.N_CH(2), .LANE(1), .ADDR_W(7), .DATA_W(8), .SIZE_W(4),
                           .TIMEOUT(Tmo1))
        u_dut1 (.clock(clk), .reset(rst_n), .bus(if1.master));

    assign if0.cmd_valid      = cmd_valid & ~sel;
    assign if1.cmd_valid      = cmd_valid & sel;
    assign if0.cmd_write      = cmd_write;
    assign if1.cmd_write      = cmd_write;
    assign if0.cmd_addr       = cmd_addr;
    assign if1.cmd_addr       = cmd_addr;
    assign if0.cmd_wdata      = cmd_wdata;
    assign if1.cmd_wdata      = cmd_wdata;
    assign if0.cmd_size       = cmd_size;
    assign if1.cmd_size       = cmd_size;
    assign if0.rsp_ready      = rsp_ready;
    assign if1.rsp_ready      = rsp_ready;
    assign if0.Sout_Rdata_ram = rdat;
    assign if1.Sout_Rdata_ram = rdat;
    assign if0.Sout_DataRdy   = dr;
    assign if1.Sout_DataRdy   = dr;

    logic        v_cmd_ready, v_rsp_valid, v_rsp_err;
    logic [7:0]  v_rsp_rdata;
    logic [41:0] v_s;

    assign v_cmd_ready = sel ? if1.cmd_ready : if0.cmd_ready;
    assign v_rsp_valid = sel ? if1.rsp_valid : if0.rsp_valid;
    assign v_rsp_err   = sel ? if1.rsp_err   : if0.rsp_err;
    assign v_rsp_rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
    assign v_s = sel ? {if1.S_oe_ram, if1.S_we_ram, if1.S_addr_ram, if1.S_Wdata_ram,
                        if1.S_data_ram_size}
                     : {if0.S_oe_ram, if0.S_we_ram, if0.S_addr_ram, if0.S_Wdata_ram,
                        if0.S_data_ram_size};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        logic       wr;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [3:0] size;
        logic [7:0] rd;
        int         lat;   // REQ cycle (1-based) carrying DataRdy; 0 = never
        int         bp;    // cycles of rsp_ready=0 while the response is shown
    } vec_t;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } rsp_t;

    vec_t vecs[9];
    rsp_t sb[$];
    int   n_vec;
    int   n_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          tmo;
        int          held;
        logic        e_err;
        int          e_held;
        logic [7:0]  e_rdata;
        logic [1:0]  e_oe, e_we;
        logic [13:0] e_addr;
        logic [15:0] e_wdata;
        logic [7:0]  e_size;
        logic [7:0]  keep;
        rsp_t        r;

        tmo     = (v.d == 1) ? Tmo1 : Tmo0;
        e_err   = (v.lat == 0) || (v.lat > tmo);
        e_held  = e_err ? tmo : v.lat;
        e_rdata = (!e_err && !v.wr) ? v.rd : 8'h00;
        e_oe = '0; e_we = '0; e_addr = '0; e_wdata = '0; e_size = '0;
        if (v.wr) e_we[v.d] = 1'b1;
        else      e_oe[v.d] = 1'b1;
        e_addr[v.d*7 +: 7] = v.addr;
        if (v.wr) e_wdata[v.d*8 +: 8] = v.wdata;
        e_size[v.d*4 +: 4] = v.size;

        sel = (v.d == 1);
        #1;
        check("cmd_ready_idle", v_cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = v.wr;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        cmd_size  = v.size;
        r.err   = e_err;
        r.rdata = e_rdata;
        sb.push_back(r);
        @(posedge clk);
        #1;
        // scramble the command fields: only the handshake sample may matter
        cmd_valid = 1'b0;
        cmd_write = ~v.wr;
        cmd_addr  = 7'($urandom);
        cmd_wdata = 8'($urandom);
        cmd_size  = 4'($urandom);
        dr   = (v.d == 1) ? 2'b01 : 2'b10;   // other lane chatters, must be ignored
        rdat = 16'hC3C3;
        held = 0;
        @(negedge clk);
        while (!v_rsp_valid && held < 40) begin
            held++;
            check("req_bus", v_s, {e_oe, e_we, e_addr, e_wdata, e_size});
            if (held == v.lat) begin
                dr[v.d] = 1'b1;
                rdat[v.d*8 +: 8] = v.rd;
            end
            @(posedge clk);
            #1;
            dr = (v.d == 1) ? 2'b01 : 2'b10;
            @(negedge clk);
        end
        check("held_cycles", held, e_held);
        check("rsp_valid", v_rsp_valid, 1);
        check("req_dropped", v_s, 0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 0, 1);
        end else begin
            r = sb.pop_front();
            check("rsp_rdata", v_rsp_rdata, r.rdata);
            check("rsp_err", v_rsp_err, r.err);
        end
        keep = v_rsp_rdata;
        for (int i = 0; i < v.bp; i++) begin
            @(negedge clk);
            check("bp_valid", v_rsp_valid, 1);
            check("bp_rdata", v_rsp_rdata, keep);
            check("bp_ready", v_cmd_ready, 0);
        end
        dr = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("done_valid", v_rsp_valid, 0);
        check("done_err", v_rsp_err, 0);
        check("done_ready", v_cmd_ready, 1);
        check("done_rdata", v_rsp_rdata, keep);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        //            d  wr    addr   wdata  size   rd     lat bp
        vecs[0] = '{0, 1'b1, 7'h12, 8'hA5, 4'd8, 8'h00, 2, 0};
        vecs[1] = '{1, 1'b0, 7'h05, 8'h00, 4'd8, 8'h3C, 1, 0};
        vecs[2] = '{0, 1'b0, 7'h7F, 8'h11, 4'd4, 8'h5A, 0, 0};
        vecs[3] = '{0, 1'b0, 7'h33, 8'h00, 4'd8, 8'h99, 4, 0};
        vecs[4] = '{1, 1'b1, 7'h40, 8'h81, 4'd8, 8'hEE, 3, 5};
        vecs[5] = '{1, 1'b0, 7'h7E, 8'h00, 4'd2, 8'hD2, 8, 2};
        vecs[6] = '{1, 1'b0, 7'h01, 8'h00, 4'd8, 8'h44, 0, 0};
        vecs[7] = '{0, 1'b1, 7'h2A, 8'h6B, 4'd8, 8'h00, 5, 1};
        vecs[8] = '{1, 1'b0, 7'h05, 8'h00, 4'd8, 8'h77, 2, 0};

        sel = 1'b0;
        rst_n = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr = 7'h12;
        cmd_wdata = 8'hA5;
        cmd_size = 4'd8;
        rsp_ready = 1'b0;
        rdat = 16'h0000;
        dr = 2'b00;
        #2 rst_n = 1'b0;

        // reset held with a command pending
        repeat (3) @(negedge clk);
        check("rst_bus", v_s, 0);
        check("rst_cmd_ready", v_cmd_ready, 0);
        check("rst_rsp_valid", v_rsp_valid, 0);
        check("rst_rsp_err", v_rsp_err, 0);
        check("rst_rsp_rdata", v_rsp_rdata, 0);
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("rel_cmd_ready0", if0.cmd_ready, 1);
        check("rel_cmd_ready1", if1.cmd_ready, 1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // DataRdy while idle must not produce anything
        dr = 2'b11;
        rdat = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            check("stray_valid0", if0.rsp_valid, 0);
            check("stray_valid1", if1.rsp_valid, 0);
            check("stray_ready0", if0.cmd_ready, 1);
            check("stray_oe", {if0.S_oe_ram, if1.S_oe_ram, if0.S_we_ram, if1.S_we_ram}, 0);
        end
        dr = 2'b00;

        // reset in the middle of a read wait
        sel = 1'b1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr = 7'h05;
        cmd_size = 4'd8;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("midrst_req", if1.S_oe_ram, 2'b10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_oe", if1.S_oe_ram, 0);
        check("midrst_addr", if1.S_addr_ram, 0);
        check("midrst_valid", v_rsp_valid, 0);
        check("midrst_ready", v_cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("postrst_valid", v_rsp_valid, 0);
        end
        check("postrst_ready", v_cmd_ready, 1);

        run_vec(vecs[8]);
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
